// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer feeding a serial shift register.
// A word is accepted over a valid/ready handshake and then emitted one bit
// per clock on s_out. Back-to-back words stream without an idle bit, and
// shift_en stalls the stream without losing data.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] p_data,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic             shift_en,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(WIDTH - 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;

    logic             at_last;
    logic             handshake;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_rem;
    logic [WIDTH-1:0] shift_rem;

    // The last-bit slot is the only point in SHIFT where a new word may be
    // taken, so the following word lands with no bubble on s_out.
    assign at_last   = (state == SHIFT) && (cnt == LAST_IDX);
    assign p_ready   = reset && ((state == IDLE) || (at_last && shift_en));
    assign handshake = p_valid && p_ready;
    assign busy      = (state == SHIFT);

    // Bit selection: the shift register holds the bits still to be shown,
    // already positioned so the next one is always at the outgoing end.
    always_comb begin
        first_bit = p_data[0];
        next_bit  = shreg[0];
        load_rem  = {1'b0, p_data[WIDTH-1:1]};
        shift_rem = {1'b0, shreg[WIDTH-1:1]};
        if (MSB_FIRST) begin
            first_bit = p_data[WIDTH-1];
            next_bit  = shreg[WIDTH-1];
            load_rem  = {p_data[WIDTH-2:0], 1'b0};
            shift_rem = {shreg[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state logic: a handshake starts or continues a word; running out
    // of bits with nothing offered returns to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (handshake) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (at_last && shift_en && !handshake) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath: load on handshake, advance one bit per enabled cycle, clear
    // the serial outputs when a word ends with no successor.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            cnt     <= '0;
            s_out   <= 1'b0;
            s_valid <= 1'b0;
            s_last  <= 1'b0;
        end else if (handshake) begin
            shreg   <= load_rem;
            cnt     <= '0;
            s_out   <= first_bit;
            s_valid <= 1'b1;
            s_last  <= 1'b0;
        end else if ((state == SHIFT) && shift_en) begin
            if (at_last) begin
                shreg   <= '0;
                cnt     <= '0;
                s_out   <= 1'b0;
                s_valid <= 1'b0;
                s_last  <= 1'b0;
            end else begin
                shreg  <= shift_rem;
                cnt    <= cnt + CNT_W'(1);
                s_out  <= next_bit;
                s_last <= (cnt == PENULT_IDX);
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: an MSB-first and an LSB-first instance share
// the same stimulus and are checked every cycle against a word/bit-position
// reference model, plus directed checks on the reassembled bit streams.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] p_data = '0;
    logic         p_valid = 1'b0;
    logic         shift_en = 1'b0;

    logic m_ready, m_out, m_valid, m_last, m_busy;
    logic l_ready, l_out, l_valid, l_last, l_busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the word being shown and which bit of it is on s_out.
    bit           active = 1'b0;
    logic [W-1:0] word = '0;
    int           pos = 0;
    logic         exp_ready;
    bit           last_hs;

    // Reassembled streams, only sampled on cycles that actually advance.
    logic [31:0]  cap_m;
    logic [31:0]  cap_l;
    int           cap_n;
    int           valid_n;

    logic [W-1:0] sent_q[$];

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .p_data(p_data), .p_valid(p_valid),
        .p_ready(m_ready), .shift_en(shift_en), .s_out(m_out),
        .s_valid(m_valid), .s_last(m_last), .busy(m_busy)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .p_data(p_data), .p_valid(p_valid),
        .p_ready(l_ready), .shift_en(shift_en), .s_out(l_out),
        .s_valid(l_valid), .s_last(l_last), .busy(l_busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic expBit(input bit msb);
        if (!active) return 1'b0;
        return msb ? word[W-1-pos] : word[pos];
    endfunction

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkValue(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string step);
        exp_ready = reset && (!active || ((pos == W - 1) && shift_en));
        checkOutput({step, " msb.p_ready"}, m_ready, exp_ready);
        checkOutput({step, " msb.s_valid"}, m_valid, active);
        checkOutput({step, " msb.s_out"},   m_out,   expBit(1'b1));
        checkOutput({step, " msb.s_last"},  m_last,  active && (pos == W - 1));
        checkOutput({step, " msb.busy"},    m_busy,  active);
        checkOutput({step, " lsb.p_ready"}, l_ready, exp_ready);
        checkOutput({step, " lsb.s_valid"}, l_valid, active);
        checkOutput({step, " lsb.s_out"},   l_out,   expBit(1'b0));
        checkOutput({step, " lsb.s_last"},  l_last,  active && (pos == W - 1));
        checkOutput({step, " lsb.busy"},    l_busy,  active);
    endtask

    // One clock cycle: drive at the falling edge, check before the rising
    // edge, then move the model across the rising edge.
    task automatic applyStimulus(input string step, input logic pv,
                                 input logic [W-1:0] pd, input logic se);
        p_valid  = pv;
        p_data   = pd;
        shift_en = se;
        #1;
        checkAll(step);
        if (m_valid === 1'b1) valid_n++;
        if ((m_valid === 1'b1) && se) begin
            cap_m = {cap_m[30:0], m_out};
            cap_l = {l_out, cap_l[31:1]};
            cap_n++;
        end
        last_hs = 1'b0;
        @(posedge clk);
        if (reset) begin
            if (exp_ready && pv) begin
                word    = pd;
                pos     = 0;
                active  = 1'b1;
                last_hs = 1'b1;
            end else if (active && se) begin
                if (pos == W - 1) active = 1'b0;
                else pos++;
            end
        end
        @(negedge clk);
    endtask

    task automatic clearCapture();
        cap_m   = '0;
        cap_l   = '0;
        cap_n   = 0;
        valid_n = 0;
    endtask

    initial begin
        logic         pv_r;
        logic [W-1:0] pd_r;
        logic         se_r;
        logic [W-1:0] exp_w;

        clearCapture();
        @(negedge clk);

        // Reset held with p_valid high: everything stays quiet.
        applyStimulus("reset0", 1'b1, 8'h5A, 1'b1);
        applyStimulus("reset1", 1'b1, 8'h5A, 1'b1);
        reset = 1'b1;
        applyStimulus("idle", 1'b0, 8'h00, 1'b1);

        // Single word 0xB2.
        clearCapture();
        applyStimulus("b2_hs", 1'b1, 8'hB2, 1'b1);
        for (int i = 0; i < W; i++) applyStimulus("b2_bit", 1'b0, 8'h00, 1'b1);
        applyStimulus("b2_after", 1'b0, 8'h00, 1'b1);
        checkValue("b2 bit count", cap_n, 8);
        checkValue("b2 msb stream", int'(cap_m[7:0]), 8'hB2);
        checkValue("b2 lsb stream", int'(cap_l[31:24]), 8'hB2);

        // Back-to-back 0xA5 then 0x3C with p_valid held high.
        clearCapture();
        applyStimulus("b2b_hs", 1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < W; i++) applyStimulus("b2b_offer", 1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < W; i++) applyStimulus("b2b_tail", 1'b0, 8'h00, 1'b1);
        applyStimulus("b2b_after", 1'b0, 8'h00, 1'b1);
        checkValue("b2b valid cycles", valid_n, 16);
        checkValue("b2b msb stream", int'(cap_m[15:0]), 16'hA53C);
        checkValue("b2b lsb stream", int'(cap_l[31:16]), 16'h3CA5);

        // Stall 0xF0 on the third bit; handshake taken with shift_en low.
        clearCapture();
        applyStimulus("stall_hs", 1'b1, 8'hF0, 1'b0);
        applyStimulus("stall_b0", 1'b0, 8'h00, 1'b1);
        applyStimulus("stall_b1", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus("stall_hold", 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus("stall_run", 1'b0, 8'h00, 1'b1);
        applyStimulus("stall_after", 1'b0, 8'h00, 1'b1);
        checkValue("stall valid cycles", valid_n, 11);
        checkValue("stall msb stream", int'(cap_m[7:0]), 8'hF0);

        // Single set bit 0x01: LSB-first shows it first.
        clearCapture();
        applyStimulus("x01_hs", 1'b1, 8'h01, 1'b1);
        for (int i = 0; i < W; i++) applyStimulus("x01_bit", 1'b0, 8'h00, 1'b1);
        checkValue("x01 lsb stream", int'(cap_l[31:24]), 8'h01);
        checkValue("x01 msb stream", int'(cap_m[7:0]), 8'h01);

        // Reset mid-word: outputs clear at once, nothing left over afterwards.
        applyStimulus("mid_hs", 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus("mid_bit", 1'b0, 8'h00, 1'b1);
        reset  = 1'b0;
        active = 1'b0;
        #1;
        checkAll("mid_reset");
        @(posedge clk);
        @(negedge clk);
        checkAll("mid_reset_hold");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("mid_released", 1'b0, 8'h00, 1'b1);
        clearCapture();
        applyStimulus("mid_new_hs", 1'b1, 8'h6D, 1'b1);
        for (int i = 0; i < W; i++) applyStimulus("mid_new_bit", 1'b0, 8'h00, 1'b1);
        checkValue("post-reset word", int'(cap_m[7:0]), 8'h6D);

        // Random traffic: the source holds its offer until it is taken, and
        // every completed word must match the one sent.
        clearCapture();
        pv_r = 1'b0;
        pd_r = '0;
        for (int c = 0; c < 600; c++) begin
            if (!pv_r && ($urandom_range(0, 2) != 0)) begin
                pv_r = 1'b1;
                pd_r = W'($urandom);
            end
            se_r = ($urandom_range(0, 3) != 0);
            applyStimulus("rand", pv_r, pd_r, se_r);
            if (last_hs) begin
                sent_q.push_back(pd_r);
                pv_r = 1'b0;
            end
            if (cap_n == W) begin
                cap_n = 0;
                if (sent_q.size() == 0) begin
                    checkValue("rand queue underflow", 0, 1);
                end else begin
                    exp_w = sent_q.pop_front();
                    checkValue("rand msb word", int'(cap_m[7:0]), int'(exp_w));
                    checkValue("rand lsb word", int'(cap_l[31:24]), int'(exp_w));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out serializer that sits directly upstream of the serial_in_serial_out shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on s_out, which drives the shift register's d_in.
- Back-to-back words stream with no idle bit between them.
- A shift_en input stalls the stream without losing data.

Parameters:
- WIDTH, 8, word width in bits; legal range is 2 or more.
- MSB_FIRST, 1, 1 emits bit WIDTH-1 first; 0 emits bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- p_data  input  WIDTH  parallel word to serialize.
- p_valid  input  1  p_data is valid.
- p_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  1 = advance one bit this cycle; 0 = hold all state.
- s_out  output  1  serial data bit, registered.
- s_valid  output  1  s_out carries a valid bit, registered.
- s_last  output  1  s_out is the final bit of the word, registered.
- busy  output  1  high while in the SHIFT state.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; shift register, bit counter, s_out, s_valid and s_last all 0.
  - busy=0.
  - p_ready=0 while reset is asserted; it goes to 1 on the first cycle after release.
- States are IDLE and SHIFT. The bit counter cnt counts 0..WIDTH-1 and is internal.
- p_ready (combinational from registered state):
  - 1 in IDLE.
  - 1 in SHIFT only when cnt==WIDTH-1 and shift_en==1, which is the last-bit slot.
  - 0 otherwise.
- A handshake occurs on a rising edge with p_valid && p_ready. p_data is then captured into the internal shift register.
- Latency: the first bit of a word appears on s_out with s_valid=1 in the cycle after the handshake edge.
- IDLE -> SHIFT on handshake; cnt is set to 0.
  - shift_en has no effect in IDLE; a word is accepted regardless of shift_en.
- In SHIFT, on each edge with shift_en=1:
  - cnt increments.
  - The next bit is presented: MSB_FIRST=1 gives descending bit index, MSB_FIRST=0 gives ascending.
- In SHIFT, on an edge with shift_en=0: s_out, s_valid, s_last, cnt and the shift register all hold.
- s_last=1 exactly when s_valid=1 and cnt==WIDTH-1.
- End of word, on the edge with cnt==WIDTH-1 and shift_en=1:
  - If p_valid=1 (handshake): load the new word, cnt=0, stay in SHIFT. s_valid stays 1 and the next cycle carries the new word's first bit, so there is no bubble.
  - If p_valid=0: go to IDLE with s_valid=0, s_last=0, s_out=0.
- p_data and p_valid are ignored when p_ready=0. The upstream source must hold p_data/p_valid until the handshake; changing them earlier is illegal.
- Reset asserted mid-word: the word is abandoned. After release the block is in IDLE and no leftover bits are emitted.
- Throughput: one bit per clock while shift_en=1. A word occupies exactly WIDTH s_valid cycles, plus any stall cycles.
- s_out=0 whenever s_valid=0.

Test Plan:
- Reset: hold reset=0 for 2 cycles with p_valid=1 -> s_out=0, s_valid=0, s_last=0, busy=0, p_ready=0 throughout; after release p_ready=1 and IDLE.
- Single word, MSB_FIRST=1, WIDTH=8: p_data=8'hB2, p_valid pulse, shift_en=1 -> starting the cycle after the handshake, s_out=1,0,1,1,0,0,1,0 on 8 consecutive cycles with s_valid=1 and s_last=1 only on the 8th; then s_valid=0, busy=0.
- Back-to-back: words 8'hA5 then 8'h3C, with p_valid held high -> 16 contiguous s_valid cycles giving bits 10100101 00111100; p_ready=1 only in IDLE and on the last-bit cycles.
- Stall: 8'hF0 with shift_en=0 for 3 cycles after bit 2 -> bit 2 (value 1) held for 4 cycles total, then the sequence resumes; 11 s_valid cycles, correct order, s_last on the final 0.
- LSB-first variant (MSB_FIRST=0), p_data=8'h01 -> s_out=1,0,0,0,0,0,0,0.
- Mid-word reset: load 8'hFF, assert reset=0 after 3 bits -> outputs go to 0 immediately; after release s_valid stays 0 until a new handshake.
